// File: rtl/alu_op_sequencer.sv
// Serial loader and sequencer for a 4-op ALU: collects A, B and opcode over a
// valid/ready port, holds them on the ALU inputs, then captures the result.
module alu_op_sequencer #(
    parameter int unsigned NB_size = 16,
    parameter int unsigned NB_cnt  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic [NB_size-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [NB_size-1:0] o_aluA,
    output logic [NB_size-1:0] o_aluB,
    output logic [1:0]         o_aluSel,
    input  logic [NB_size-1:0] i_aluC,
    input  logic               i_addCarry,
    input  logic               i_subCarry,
    output logic [NB_size-1:0] o_result,
    output logic               o_carry,
    output logic               o_zero,
    output logic               o_done,
    output logic [NB_cnt-1:0]  o_op_count
);

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StExec,
        StDone
    } state_e;

    state_e state_q, state_d;
    logic   accept;
    logic   capture;
    logic   count_en;
    logic   carry_sel;

    // Ready is a pure state decode so it never depends on i_valid.
    assign o_ready  = (state_q == StWaitA) || (state_q == StWaitB) || (state_q == StWaitOp);
    // Clear wins over a simultaneous load, capture or completion.
    assign accept   = i_valid & o_ready & ~i_clear;
    assign capture  = (state_q == StExec) & ~i_clear;
    assign count_en = (state_q == StDone) & ~i_clear;
    assign o_done   = count_en;

    // Next-state logic: load sequence, single-cycle EXEC and DONE, clear to WAIT_A.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitA:  if (accept) state_d = StWaitB;
            StWaitB:  if (accept) state_d = StWaitOp;
            StWaitOp: if (accept) state_d = StExec;
            StExec:   state_d = StDone;
            StDone:   state_d = StWaitA;
            default:  state_d = StWaitA;
        endcase
        if (i_clear) begin
            state_d = StWaitA;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StWaitA;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and select registers; each holds until its own load slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_aluA   <= '0;
            o_aluB   <= '0;
            o_aluSel <= 2'b00;
        end else if (accept) begin
            if (state_q == StWaitA)  o_aluA   <= i_data;
            if (state_q == StWaitB)  o_aluB   <= i_data;
            if (state_q == StWaitOp) o_aluSel <= i_data[1:0];
        end
    end

    // Only add and sub produce a meaningful carry; logic ops report 0.
    always_comb begin
        carry_sel = 1'b0;
        case (o_aluSel)
            2'b00:   carry_sel = i_addCarry;
            2'b01:   carry_sel = i_subCarry;
            default: carry_sel = 1'b0;
        endcase
    end

    // Result capture at the end of EXEC; held otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result <= '0;
            o_carry  <= 1'b0;
            o_zero   <= 1'b0;
        end else if (capture) begin
            o_result <= i_aluC;
            o_carry  <= carry_sel;
            o_zero   <= (i_aluC == '0);
        end
    end

    // Completed-operation counter, wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_op_count <= '0;
        end else if (count_en) begin
            o_op_count <= o_op_count + NB_cnt'(1);
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and a
// spec-level reference for results, carries and operation count.
module tb_alu_op_sequencer;

    localparam int unsigned NB = 16;
    localparam int unsigned NC = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_clear = 1'b0;
    logic [NB-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [NB-1:0] o_aluA, o_aluB, i_aluC, o_result;
    logic [1:0]    o_aluSel;
    logic          i_addCarry, i_subCarry, o_carry, o_zero, o_done;
    logic [NC-1:0] o_op_count;
    logic          force_c = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [NB-1:0] last_res = '0;

    alu_op_sequencer #(.NB_size(NB), .NB_cnt(NC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .o_aluA(o_aluA), .o_aluB(o_aluB),
        .o_aluSel(o_aluSel), .i_aluC(i_aluC), .i_addCarry(i_addCarry),
        .i_subCarry(i_subCarry), .o_result(o_result), .o_carry(o_carry),
        .o_zero(o_zero), .o_done(o_done), .o_op_count(o_op_count)
    );

    always #5 i_clk = ~i_clk;

    // Bench ALU: add carry is the unsigned carry-out, sub carry is the borrow.
    always_comb begin
        logic [NB:0] sum;
        sum = {1'b0, o_aluA} + {1'b0, o_aluB};
        case (o_aluSel)
            2'b00:   i_aluC = sum[NB-1:0];
            2'b01:   i_aluC = o_aluA - o_aluB;
            2'b10:   i_aluC = o_aluA & o_aluB;
            default: i_aluC = o_aluA | o_aluB;
        endcase
        i_addCarry = force_c | sum[NB];
        i_subCarry = force_c | (o_aluA < o_aluB);
    end

    function automatic logic [NB-1:0] ref_res(input int unsigned a, b, op);
        int unsigned r;
        case (op % 4)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return NB'(r % (1 << NB));
    endfunction

    function automatic logic ref_car(input int unsigned a, b, op);
        if (op % 4 == 0) return (a + b) >= (1 << NB);
        if (op % 4 == 1) return a < b;
        return 1'b0;
    endfunction

    // Present one word and hold it until the sequencer accepts it.
    task automatic send(input logic [NB-1:0] d);
        int n = 0;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_data  = d;
        while (!o_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 20) begin
            n_fail++;
            $display("FAIL send_timeout ready stayed %b, required 1", o_ready);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Load a full operation and report what the DUT produced.
    task automatic run_op(input logic [NB-1:0] a, b, opw, output int lat,
                          output logic [NB-1:0] res, output logic car, zer, done_after,
                          output logic [NC-1:0] cnt);
        send(a);
        send(b);
        send(opw);
        lat = -1;
        res = 'x;
        car = 1'bx;
        zer = 1'bx;
        for (int i = 0; i < 6; i++) begin
            if (o_done === 1'b1) begin
                lat = i;
                res = o_result;
                car = o_carry;
                zer = o_zero;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        @(posedge i_clk);
        #1;
        done_after = o_done;
        cnt = o_op_count;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready got %b need 1", o_ready); end
        n_checks++; if ({o_aluA, o_aluB, o_aluSel} !== '0) begin n_fail++;
            $display("FAIL reset_alu_in got %h %h %b need 0", o_aluA, o_aluB, o_aluSel); end
        n_checks++; if ({o_result, o_carry, o_zero, o_done} !== '0) begin n_fail++;
            $display("FAIL reset_result got %h %b %b %b need 0", o_result, o_carry, o_zero,
                     o_done); end
        n_checks++; if (o_op_count !== '0) begin n_fail++;
            $display("FAIL reset_count got %0d need 0", o_op_count); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; logic [NB-1:0] res; logic car, zer, da; logic [NC-1:0] cnt;
        run_op(16'h0005, 16'h0003, 16'h0000, lat, res, car, zer, da, cnt);
        exp_cnt++; last_res = 16'h0008;
        n_checks++; if (lat !== 1) begin n_fail++;
            $display("FAIL add_latency got %0d edges need 1", lat); end
        n_checks++; if (res !== 16'h0008) begin n_fail++;
            $display("FAIL add_result got %h need 0008", res); end
        n_checks++; if ({car, zer} !== 2'b00) begin n_fail++;
            $display("FAIL add_flags got c=%b z=%b need 0 0", car, zer); end
        n_checks++; if (da !== 1'b0) begin n_fail++;
            $display("FAIL add_done_pulse got %b need 0 after one cycle", da); end
        n_checks++; if (cnt !== NC'(1)) begin n_fail++;
            $display("FAIL add_count got %0d need 1", cnt); end
    endtask

    task automatic test_carry_zero();
        int lat; logic [NB-1:0] res; logic car, zer, da; logic [NC-1:0] cnt;
        run_op(16'hFFFF, 16'h0001, 16'h0000, lat, res, car, zer, da, cnt);
        exp_cnt++;
        n_checks++; if ({res, car, zer} !== {16'h0000, 1'b1, 1'b1}) begin n_fail++;
            $display("FAIL add_carry got %h c=%b z=%b need 0000 1 1", res, car, zer); end
        run_op(16'h0003, 16'h0003, 16'h0001, lat, res, car, zer, da, cnt);
        exp_cnt++; last_res = 16'h0000;
        n_checks++; if ({res, car, zer} !== {16'h0000, 1'b0, 1'b1}) begin n_fail++;
            $display("FAIL sub_zero got %h c=%b z=%b need 0000 0 1", res, car, zer); end
        n_checks++; if (cnt !== NC'(exp_cnt)) begin n_fail++;
            $display("FAIL sub_count got %0d need %0d", cnt, exp_cnt); end
    endtask

    task automatic test_logic_sel();
        int lat; logic [NB-1:0] res; logic car, zer, da; logic [NC-1:0] cnt;
        force_c = 1'b1;
        run_op(16'h00F0, 16'h0FF0, 16'hFFFE, lat, res, car, zer, da, cnt);
        force_c = 1'b0;
        exp_cnt++; last_res = 16'h00F0;
        n_checks++; if (o_aluSel !== 2'b10) begin n_fail++;
            $display("FAIL and_sel got %b need 10", o_aluSel); end
        n_checks++; if ({res, car, zer} !== {16'h00F0, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL and_result got %h c=%b z=%b need 00f0 0 0", res, car, zer); end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] w [15];
        for (int k = 0; k < 15; k++) begin
            @(negedge i_clk);
            w[k] = NB'($urandom);
            i_valid = 1'b1;
            i_data  = w[k];
            n_checks++; if (o_ready !== ((k % 5) < 3)) begin n_fail++;
                $display("FAIL b2b_ready cycle %0d got %b need %b", k, o_ready, (k % 5) < 3); end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        exp_cnt += 3;
        last_res = ref_res(w[10], w[11], w[12]);
        n_checks++; if (o_result !== last_res || o_carry !== ref_car(w[10], w[11], w[12]))
            begin n_fail++;
            $display("FAIL b2b_result got %h c=%b need %h c=%b", o_result, o_carry, last_res,
                     ref_car(w[10], w[11], w[12])); end
        n_checks++; if (o_op_count !== NC'(exp_cnt)) begin n_fail++;
            $display("FAIL b2b_count got %0d need %0d", o_op_count, exp_cnt % 256); end
    endtask

    task automatic test_clear();
        logic [NB-1:0] b_keep;
        bit seen_done = 0;
        send(16'h1234);
        send(16'h0011);
        send(16'h0000);
        i_clear = 1'b1;                       // now in EXEC
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (o_done === 1'b1) seen_done = 1;
            @(posedge i_clk);
            #1;
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++;
            $display("FAIL clear_exec_done got pulse need none"); end
        n_checks++; if (o_result !== last_res) begin n_fail++;
            $display("FAIL clear_exec_result got %h need %h", o_result, last_res); end
        n_checks++; if (o_op_count !== NC'(exp_cnt)) begin n_fail++;
            $display("FAIL clear_exec_count got %0d need %0d", o_op_count, exp_cnt % 256); end
        send(16'h5A5A);
        n_checks++; if (o_aluA !== 16'h5A5A || o_aluB !== 16'h0011) begin n_fail++;
            $display("FAIL clear_reload_a got A=%h B=%h need 5a5a 0011", o_aluA, o_aluB); end
        b_keep = o_aluB;
        @(negedge i_clk);                     // WAIT_B: clear with a valid word
        i_valid = 1'b1; i_data = 16'hBEEF; i_clear = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0; i_clear = 1'b0;
        n_checks++; if (o_aluB !== b_keep) begin n_fail++;
            $display("FAIL clear_wb_drop got B=%h need %h", o_aluB, b_keep); end
        send(16'h0077);                       // must land in A again
        n_checks++; if (o_aluA !== 16'h0077 || o_aluB !== b_keep) begin n_fail++;
            $display("FAIL clear_wb_state got A=%h B=%h need 0077 %h", o_aluA, o_aluB, b_keep);
        end
        send(16'h0100);
        send(16'h0003);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        exp_cnt++; last_res = 16'h0177;
        n_checks++; if (o_result !== 16'h0177 || o_op_count !== NC'(exp_cnt)) begin n_fail++;
            $display("FAIL clear_recover got %h cnt %0d need 0177 cnt %0d", o_result,
                     o_op_count, exp_cnt % 256); end
    endtask

    task automatic test_random();
        int lat; logic [NB-1:0] res, a, b, op; logic car, zer, da; logic [NC-1:0] cnt;
        for (int i = 0; i < 40; i++) begin
            a = NB'($urandom); b = NB'($urandom); op = NB'($urandom);
            if (i % 4 == 0) b = a;
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            run_op(a, b, op, lat, res, car, zer, da, cnt);
            exp_cnt++; last_res = ref_res(a, b, op);
            n_checks++;
            if (lat !== 1 || res !== last_res || car !== ref_car(a, b, op) ||
                zer !== (last_res == 0) || cnt !== NC'(exp_cnt)) begin
                n_fail++;
                $display("FAIL rand_op%0d got lat=%0d r=%h c=%b z=%b n=%0d need 1 %h %b %b %0d",
                         i, lat, res, car, zer, cnt, last_res, ref_car(a, b, op),
                         last_res == 0, exp_cnt % 256);
            end
        end
    endtask

    task automatic test_wrap();
        int lat; logic [NB-1:0] res; logic car, zer, da; logic [NC-1:0] cnt;
        while (exp_cnt % 256 != 255) begin
            run_op(NB'($urandom), NB'($urandom), NB'($urandom), lat, res, car, zer, da, cnt);
            exp_cnt++;
        end
        n_checks++; if (o_op_count !== 8'd255) begin n_fail++;
            $display("FAIL wrap_pre got %0d need 255", o_op_count); end
        run_op(16'h0001, 16'h0001, 16'h0000, lat, res, car, zer, da, cnt);
        exp_cnt++;
        n_checks++; if (cnt !== 8'd0) begin n_fail++;
            $display("FAIL wrap_count got %0d need 0", cnt); end
    endtask

    task automatic test_async_reset();
        send(16'hAAAA);
        send(16'h5555);
        #3;
        i_rst_n = 1'b0;                       // mid-cycle, in WAIT_OP
        #1;
        n_checks++; if ({o_aluA, o_aluB, o_aluSel, o_result, o_carry, o_zero, o_done} !== '0)
            begin n_fail++;
            $display("FAIL arst_outputs got %h %h %b %h %b %b %b need 0", o_aluA, o_aluB,
                     o_aluSel, o_result, o_carry, o_zero, o_done); end
        n_checks++; if (o_op_count !== '0 || o_ready !== 1'b1) begin n_fail++;
            $display("FAIL arst_count_ready got %0d %b need 0 1", o_op_count, o_ready); end
        exp_cnt = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_zero();
        test_logic_sel();
        test_back_to_back();
        test_clear();
        test_random();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
